// File: rtl/wm_pkg.sv
// Shared definitions for the Wu-Manber dispatcher and its workers.
//   slot_state_e : per-worker slot state
//   wm_res_t     : result record {tag, match, timeout} at the default tag width
//   rr_first     : round-robin search for the first set request at/after a pointer
package wm_pkg;

  localparam int unsigned WM_DATA_W    = 160;
  localparam int unsigned WM_TAG_W     = 8;
  localparam int unsigned WM_MAX_SLOTS = 16;
  localparam int unsigned WM_SLOT_IW   = $clog2(WM_MAX_SLOTS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    PEND = 2'd2
  } slot_state_e;

  typedef struct packed {
    logic [WM_TAG_W-1:0] tag;
    logic                match;
    logic                timeout;
  } wm_res_t;

  // Index of the first set bit of req[n-1:0] at or after ptr, wrapping; -1 if none.
  function automatic int rr_first(input logic [WM_MAX_SLOTS-1:0] req,
                                  input int unsigned n,
                                  input int unsigned ptr);
    int sel;
    sel = -1;
    for (int unsigned k = 0; k < WM_MAX_SLOTS; k++) begin
      if (k < n) begin
        int unsigned idx;
        idx = (ptr + k) % n;
        if (sel < 0 && req[idx[WM_SLOT_IW-1:0]]) sel = int'(idx);
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/wm_res_fifo.sv
// First-word-fall-through result FIFO, DEPTH a power of 2 (>= 2).
//   clk_i, rst_ni      : clock, async active-low reset
//   push_i, wdata_i    : write request/data (accepted when not full, or when popping)
//   pop_i, rdata_o     : read request / head entry
//   full_o, empty_o    : status
module wm_res_fifo
#(
  parameter int unsigned W     = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic         do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot being written, so a full FIFO may still accept.
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + {{AW{1'b0}}, 1'b1};
    if (do_pop)  rptr_d = rptr_q + {{AW{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/wm_dispatch.sv
// Work dispatcher for the Wu-Manber search array.
//   in_valid/in_ready/in_data/in_tag : tagged payload windows from the front end
//   wk_din/wk_start                  : per-worker window and one-cycle start pulse
//   wk_done/wk_match                 : per-worker completion and match flag
//   res_valid/res_ready/res_*        : tagged results, in collection order
//   stat_pkts/stat_matches           : accepted windows / popped matching results
// rst is asynchronous, active-low.
module wm_dispatch
  import wm_pkg::*;
#(
  parameter int unsigned NUM_WORKERS = 4,
  parameter int unsigned DATA_W      = WM_DATA_W,
  parameter int unsigned TAG_W       = WM_TAG_W,
  parameter int unsigned RES_DEPTH   = 4,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_data,
  input  logic [TAG_W-1:0]              in_tag,
  output logic [NUM_WORKERS*DATA_W-1:0] wk_din,
  output logic [NUM_WORKERS-1:0]        wk_start,
  input  logic [NUM_WORKERS-1:0]        wk_done,
  input  logic [NUM_WORKERS-1:0]        wk_match,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [TAG_W-1:0]              res_tag,
  output logic                          res_match,
  output logic                          res_timeout,
  output logic [31:0]                   stat_pkts,
  output logic [31:0]                   stat_matches
);

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned PW = (NUM_WORKERS > 1) ? $clog2(NUM_WORKERS) : 1;
  localparam int unsigned RW = TAG_W + 2;

  slot_state_e                   state_q [NUM_WORKERS];
  slot_state_e                   state_d [NUM_WORKERS];
  logic [TAG_W-1:0]              tag_q   [NUM_WORKERS];
  logic [TAG_W-1:0]              tag_d   [NUM_WORKERS];
  logic [CW-1:0]                 cnt_q   [NUM_WORKERS];
  logic [CW-1:0]                 cnt_d   [NUM_WORKERS];
  logic [NUM_WORKERS-1:0]        match_q, match_d, to_q, to_d, start_q, start_d;
  logic [NUM_WORKERS*DATA_W-1:0] din_q, din_d;
  logic [PW-1:0]                 disp_ptr_q, disp_ptr_d, col_ptr_q, col_ptr_d;
  logic [31:0]                   pkts_q, pkts_d, matches_q, matches_d;

  logic [WM_MAX_SLOTS-1:0] idle_vec, pend_vec;
  int                      grant, pick;
  logic                    accept, pop, push, fifo_full, fifo_empty;
  logic [RW-1:0]           push_data, head;

  always_comb begin
    idle_vec = '0;
    pend_vec = '0;
    for (int unsigned i = 0; i < NUM_WORKERS; i++) begin
      idle_vec[i] = (state_q[i] == IDLE);
      pend_vec[i] = (state_q[i] == PEND);
    end
  end

  assign in_ready = rst && (|idle_vec);
  assign accept   = in_valid && in_ready;
  assign grant    = rr_first(idle_vec, NUM_WORKERS, 32'(disp_ptr_q));
  assign pick     = rr_first(pend_vec, NUM_WORKERS, 32'(col_ptr_q));
  assign pop      = res_valid && res_ready;
  assign push     = (pick >= 0) && (!fifo_full || pop);

  always_comb begin
    state_d    = state_q;
    tag_d      = tag_q;
    cnt_d      = cnt_q;
    match_d    = match_q;
    to_d       = to_q;
    din_d      = din_q;
    start_d    = '0;
    disp_ptr_d = disp_ptr_q;
    col_ptr_d  = col_ptr_q;
    pkts_d     = pkts_q;
    matches_d  = matches_q;
    push_data  = '0;

    for (int unsigned i = 0; i < NUM_WORKERS; i++) begin
      case (state_q[i])
        IDLE: if (accept && grant == int'(i)) begin
          state_d[i]                  = BUSY;
          tag_d[i]                    = in_tag;
          din_d[i*DATA_W +: DATA_W]   = in_data;
          start_d[i]                  = 1'b1;
          cnt_d[i]                    = '0;
        end
        BUSY: begin
          // Done takes priority over a timeout expiring on the same edge.
          if (wk_done[i]) begin
            state_d[i] = PEND;
            match_d[i] = wk_match[i];
            to_d[i]    = 1'b0;
          end else if (cnt_q[i] == CW'(TIMEOUT)) begin
            state_d[i] = PEND;
            match_d[i] = 1'b0;
            to_d[i]    = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        PEND: if (push && pick == int'(i)) begin
          state_d[i] = IDLE;
          push_data  = {tag_q[i], match_q[i], to_q[i]};
        end
        default: state_d[i] = IDLE;
      endcase
    end

    if (accept) begin
      disp_ptr_d = PW'((grant + 1) % int'(NUM_WORKERS));
      pkts_d     = pkts_q + 32'd1;
    end
    if (push) col_ptr_d = PW'((pick + 1) % int'(NUM_WORKERS));
    if (pop && head[1]) matches_d = matches_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_WORKERS; i++) begin
        state_q[i] <= IDLE;
        tag_q[i]   <= '0;
        cnt_q[i]   <= '0;
      end
      match_q    <= '0;
      to_q       <= '0;
      start_q    <= '0;
      din_q      <= '0;
      disp_ptr_q <= '0;
      col_ptr_q  <= '0;
      pkts_q     <= '0;
      matches_q  <= '0;
    end else begin
      state_q    <= state_d;
      tag_q      <= tag_d;
      cnt_q      <= cnt_d;
      match_q    <= match_d;
      to_q       <= to_d;
      start_q    <= start_d;
      din_q      <= din_d;
      disp_ptr_q <= disp_ptr_d;
      col_ptr_q  <= col_ptr_d;
      pkts_q     <= pkts_d;
      matches_q  <= matches_d;
    end
  end

  wm_res_fifo #(
    .W     (RW),
    .DEPTH (RES_DEPTH)
  ) u_res_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (push),
    .wdata_i (push_data),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign wk_din       = din_q;
  assign wk_start     = start_q;
  assign res_valid    = !fifo_empty;
  // FIFO storage is not reset; gate the head so outputs read zero while empty.
  assign res_tag      = res_valid ? head[RW-1:2] : '0;
  assign res_match    = res_valid && head[1];
  assign res_timeout  = res_valid && head[0];
  assign stat_pkts    = pkts_q;
  assign stat_matches = matches_q;

endmodule

// File: tb/tb_wm_dispatch.sv
module tb_wm_dispatch;

  localparam int T = 20;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [159:0] in_data;
  logic [7:0]   in_tag;
  logic [639:0] wk_din;
  logic [3:0]   wk_start;
  logic [3:0]   wk_done;
  logic [3:0]   wk_match;
  logic         res_valid;
  logic         res_ready;
  logic [7:0]   res_tag;
  logic         res_match;
  logic         res_timeout;
  logic [31:0]  stat_pkts;
  logic [31:0]  stat_matches;

  wm_dispatch #(
    .NUM_WORKERS (4),
    .DATA_W      (160),
    .TAG_W       (8),
    .RES_DEPTH   (4),
    .TIMEOUT     (T)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_tag       (in_tag),
    .wk_din       (wk_din),
    .wk_start     (wk_start),
    .wk_done      (wk_done),
    .wk_match     (wk_match),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_tag      (res_tag),
    .res_match    (res_match),
    .res_timeout  (res_timeout),
    .stat_pkts    (stat_pkts),
    .stat_matches (stat_matches)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [7:0] tag;
    logic [3:0] done;
    logic [3:0] match;
    logic       rdy;
    logic [3:0] e_start;
    logic       e_rdy;
    logic       e_rv;
    logic [7:0] e_tag;
    logic       e_m;
    logic [31:0] e_pkts;
    logic [31:0] e_mt;
  } vec_t;

  vec_t tbl [20];
  int n_tests = 0;
  int n_fail  = 0;

  int exp_s [4] = '{4, 8, 1, 2};
  int dt    [8] = '{'h34, 'h31, 'h32, 'h33, 'h44, 'h41, 'h42, 'h43};
  int dm    [8] = '{0, 1, 0, 1, 0, 0, 0, 0};

  function automatic vec_t mk(int v, int tag, int done, int match, int rdy, int st,
                              int ir, int rv, int rt, int rm, int pk, int mt);
    vec_t r;
    r.v = 1'(v);       r.tag = 8'(tag);   r.done = 4'(done); r.match = 4'(match);
    r.rdy = 1'(rdy);   r.e_start = 4'(st); r.e_rdy = 1'(ir);  r.e_rv = 1'(rv);
    r.e_tag = 8'(rt);  r.e_m = 1'(rm);    r.e_pkts = 32'(pk); r.e_mt = 32'(mt);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_w(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int v, input int tag);
    in_valid = 1'(v);
    in_tag   = 8'(tag);
    in_data  = {20{in_tag}};
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    //   v  tag  done match rdy | start ir rv tag  m  pkts mt
    tbl[0]  = mk(1, 'h11, 0, 0, 1,  1, 1, 0, 0,    0, 1, 0);
    tbl[1]  = mk(0, 0,    1, 1, 1,  0, 1, 0, 0,    0, 1, 0);
    tbl[2]  = mk(0, 0,    0, 0, 1,  0, 1, 1, 'h11, 1, 1, 0);
    tbl[3]  = mk(0, 0,    0, 0, 1,  0, 1, 0, 0,    0, 1, 1);
    tbl[4]  = mk(1, 'h21, 0, 0, 1,  2, 1, 0, 0,    0, 2, 1);
    tbl[5]  = mk(1, 'h22, 0, 0, 1,  4, 1, 0, 0,    0, 3, 1);
    tbl[6]  = mk(1, 'h23, 0, 0, 1,  8, 1, 0, 0,    0, 4, 1);
    tbl[7]  = mk(1, 'h24, 0, 0, 1,  1, 0, 0, 0,    0, 5, 1);
    tbl[8]  = mk(1, 'h25, 0, 0, 1,  0, 0, 0, 0,    0, 5, 1);
    tbl[9]  = mk(1, 'h25, 2, 0, 1,  0, 0, 0, 0,    0, 5, 1);
    tbl[10] = mk(1, 'h25, 0, 0, 0,  0, 1, 1, 'h21, 0, 5, 1);
    tbl[11] = mk(1, 'h25, 0, 0, 1,  2, 0, 0, 0,    0, 6, 1);
    tbl[12] = mk(0, 0,    14, 4, 1, 0, 0, 0, 0,    0, 6, 1);
    tbl[13] = mk(0, 0,    0, 0, 1,  0, 1, 1, 'h22, 1, 6, 1);
    tbl[14] = mk(0, 0,    0, 0, 1,  0, 1, 1, 'h23, 0, 6, 2);
    tbl[15] = mk(0, 0,    0, 0, 1,  0, 1, 1, 'h25, 0, 6, 2);
    tbl[16] = mk(0, 0,    0, 0, 1,  0, 1, 0, 0,    0, 6, 2);
    tbl[17] = mk(0, 0,    5, 5, 1,  0, 1, 0, 0,    0, 6, 2);
    tbl[18] = mk(0, 0,    0, 0, 1,  0, 1, 1, 'h24, 1, 6, 2);
    tbl[19] = mk(0, 0,    0, 0, 1,  0, 1, 0, 0,    0, 6, 3);

    // Reset with a window already offered.
    rst = 1'b0; res_ready = 1'b1; wk_done = '0; wk_match = '0;
    drive(1, 'h11);
    step(); step();
    chk("rst in_ready",   32'(in_ready), 0);
    chk("rst wk_start",   32'(wk_start), 0);
    chk("rst wk_din",     32'(|wk_din), 0);
    chk("rst res_valid",  32'(res_valid), 0);
    chk("rst res_fields", 32'({res_tag, res_match, res_timeout}), 0);
    chk("rst stat_pkts",  stat_pkts, 0);
    chk("rst stat_match", stat_matches, 0);
    rst = 1'b1;

    for (int i = 0; i < 20; i++) begin
      drive(32'(tbl[i].v), 32'(tbl[i].tag));
      wk_done   = tbl[i].done;
      wk_match  = tbl[i].match;
      res_ready = tbl[i].rdy;
      step();
      chk($sformatf("v%0d wk_start", i),  32'(wk_start),  32'(tbl[i].e_start));
      chk($sformatf("v%0d in_ready", i),  32'(in_ready),  32'(tbl[i].e_rdy));
      chk($sformatf("v%0d res_valid", i), 32'(res_valid), 32'(tbl[i].e_rv));
      if (tbl[i].e_rv) begin
        chk($sformatf("v%0d res_tag", i),     32'(res_tag),     32'(tbl[i].e_tag));
        chk($sformatf("v%0d res_match", i),   32'(res_match),   32'(tbl[i].e_m));
        chk($sformatf("v%0d res_timeout", i), 32'(res_timeout), 0);
      end
      chk($sformatf("v%0d stat_pkts", i),    stat_pkts,    tbl[i].e_pkts);
      chk($sformatf("v%0d stat_matches", i), stat_matches, tbl[i].e_mt);
      for (int unsigned w = 0; w < 4; w++)
        if (tbl[i].e_start[w])
          chk_w($sformatf("v%0d wk_din%0d", i, w), wk_din[w*160 +: 160], {20{tbl[i].tag}});
    end
    drive(0, 0); wk_done = '0; wk_match = '0;

    // Backpressure: 4 results queued, 2 slots PEND, 2 BUSY.
    res_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      drive(1, 'h31 + j); step();
      chk($sformatf("bp1 start%0d", j), 32'(wk_start), 32'(exp_s[j]));
    end
    drive(0, 0); wk_done = 4'hF; wk_match = 4'b0101; step();
    wk_done = '0; wk_match = '0;
    repeat (5) step();
    chk("bp full res_valid", 32'(res_valid), 1);
    chk("bp full in_ready",  32'(in_ready), 1);
    for (int j = 0; j < 4; j++) begin
      drive(1, 'h41 + j); step();
      chk($sformatf("bp2 start%0d", j), 32'(wk_start), 32'(exp_s[j]));
    end
    drive(0, 0); wk_done = 4'b1100; step(); wk_done = '0; step(); step();
    chk("bp in_ready held", 32'(in_ready), 0);
    chk("bp head held",     32'(res_tag), 'h34);
    wk_done = 4'b0011; step(); wk_done = '0; step();
    res_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("drain%0d valid", j), 32'(res_valid), 1);
      chk($sformatf("drain%0d tag", j),   32'(res_tag),   32'(dt[j]));
      chk($sformatf("drain%0d match", j), 32'(res_match), 32'(dm[j]));
      step();
    end
    chk("drain empty",    32'(res_valid), 0);
    chk("drain matches",  stat_matches, 5);
    chk("drain pkts",     stat_pkts, 14);

    // Timeout on slot 2, then a late done that must be ignored.
    res_ready = 1'b0;
    drive(1, 'h51); step(); drive(0, 0);
    chk("to start", 32'(wk_start), 4);
    for (int j = 0; j < T + 1; j++) begin
      step();
      chk($sformatf("to quiet%0d", j), 32'(res_valid), 0);
    end
    step();
    chk("to valid",   32'(res_valid), 1);
    chk("to tag",     32'(res_tag), 'h51);
    chk("to flag",    32'(res_timeout), 1);
    chk("to match",   32'(res_match), 0);
    wk_done = 4'b0100; wk_match = 4'b0100; step();
    wk_done = '0; wk_match = '0; step(); step();
    res_ready = 1'b1; step(); res_ready = 1'b0;
    chk("late done ignored", 32'(res_valid), 0);
    chk("to stat_matches",   stat_matches, 5);

    // Done and timeout on the same edge on slot 3: done wins.
    drive(1, 'h52); step(); drive(0, 0);
    chk("dw start", 32'(wk_start), 8);
    repeat (T) step();
    wk_done = 4'b1000; wk_match = 4'b1000; step();
    wk_done = '0; wk_match = '0; step();
    chk("dw valid",   32'(res_valid), 1);
    chk("dw tag",     32'(res_tag), 'h52);
    chk("dw match",   32'(res_match), 1);
    chk("dw timeout", 32'(res_timeout), 0);
    res_ready = 1'b1; step(); res_ready = 1'b0;
    chk("dw stat_matches", stat_matches, 6);

    // Reset mid-operation: 2 queued results, 3 busy slots.
    drive(1, 'h61); step(); chk("mr start61", 32'(wk_start), 1);
    drive(1, 'h62); step(); chk("mr start62", 32'(wk_start), 2);
    drive(0, 0); wk_done = 4'b0011; step(); wk_done = '0; step(); step();
    drive(1, 'h63); step(); chk("mr start63", 32'(wk_start), 4);
    drive(1, 'h64); step(); chk("mr start64", 32'(wk_start), 8);
    drive(1, 'h65); step(); chk("mr start65", 32'(wk_start), 1);
    drive(0, 0);
    chk("mr pre valid", 32'(res_valid), 1);
    chk("mr pre tag",   32'(res_tag), 'h61);
    chk("mr pre pkts",  stat_pkts, 21);
    rst = 1'b0;
    #1;
    chk("mr res_valid", 32'(res_valid), 0);
    chk("mr wk_start",  32'(wk_start), 0);
    chk("mr wk_din",    32'(|wk_din), 0);
    chk("mr in_ready",  32'(in_ready), 0);
    chk("mr pkts",      stat_pkts, 0);
    chk("mr matches",   stat_matches, 0);
    step();
    rst = 1'b1;
    drive(1, 'h70); step(); drive(0, 0);
    chk("mr first start", 32'(wk_start), 1);
    chk("mr first pkts",  stat_pkts, 1);
    step();
    chk("mr start drop",  32'(wk_start), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
